// File: rtl/instruction_loader.sv
// instruction_loader: write-side loader for the 8k-word instruction memory.
// Accepts a framed byte stream (LEN_HI, LEN_LO, 4*N big-endian data bytes,
// XOR checksum), writes assembled words through memory port A, and holds
// the CPU in reset while a load is in flight or after a failed load.
module instruction_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  // Number of words that fit between BASE_ADDR and the top of memory.
  localparam longint CAPACITY = (longint'(1) << ADDR_WIDTH) - longint'(BASE_ADDR);

  logic [2:0]  state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;
  logic [23:0] shreg;   // first three bytes of the word in progress
  logic        xfer;
  logic [15:0] len_new;

  assign xfer     = rx_valid && rx_ready;
  assign len_new  = {len[15:8], rx_data};
  assign busy     = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CHECK);
  assign rx_ready = busy;
  assign cpu_hold = busy || error;

  // Frame parser, word assembly, memory write pulse and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len      <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      csum     <= '0;
      shreg    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (xfer && state != S_CHECK) csum <= csum ^ rx_data;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state    <= S_LEN_HI;
            done     <= 1'b0;
            error    <= 1'b0;
            csum     <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        S_LEN_HI: if (xfer) begin
          len[15:8] <= rx_data;
          state     <= S_LEN_LO;
        end
        S_LEN_LO: if (xfer) begin
          len[7:0] <= rx_data;
          if (longint'(len_new) > CAPACITY) begin
            state <= S_ERROR;
            error <= 1'b1;
          end else if (len_new == 16'd0) begin
            state <= S_CHECK;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (xfer) begin
          shreg    <= {shreg[15:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            wr_en    <= 1'b1;
            wr_addr  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_idx);
            wr_data  <= {shreg, rx_data};
            word_idx <= word_idx + 16'd1;
            if (word_idx == len - 16'd1) state <= S_CHECK;
          end
        end
        S_CHECK: if (xfer) begin
          if (rx_data == csum) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed frames with hand-computed results.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, error, cpu_hold;

  int n_chk  = 0;
  int n_fail = 0;

  logic [12:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  fr [0:10];

  instruction_loader #(.ADDR_WIDTH(13), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  // Log every write pulse seen mid-cycle.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte and return #1 after the edge that consumed it.
  task automatic send_byte(input logic [7:0] b);
    logic r;
    int   n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      r = rx_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 20) begin
        chk("handshake_timeout", 1'b0, 1'b1);
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  // Compare the logged writes against the two-word frame's contents.
  task automatic chk_two_words(input string tag);
    chk({tag, "_nwr"}, wa_q.size(), 2);
    if (wa_q.size() >= 2) begin
      chk({tag, "_a0"}, wa_q[0], 13'd0);
      chk({tag, "_d0"}, wd_q[0], 32'hDEADBEEF);
      chk({tag, "_a1"}, wa_q[1], 13'd1);
      chk({tag, "_d1"}, wd_q[1], 32'h12345678);
    end
  endtask

  initial begin
    fr = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
           8'h12, 8'h34, 8'h56, 8'h78, 8'h28};
    rst = 1'b1; start = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_outs", {rx_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_hold}, '0);

    // Two-word load, rx_valid held high.
    clear_log();
    pulse_start();
    chk("start_busy", busy, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(fr[i]);
    chk("lat_wr_en", wr_en, 1'b1);
    chk("lat_addr", wr_addr, 13'd0);
    chk("lat_data", wr_data, 32'hDEADBEEF);
    for (int i = 6; i < 11; i++) send_byte(fr[i]);
    rx_valid = 1'b0;
    idle_cycles(2);
    chk_two_words("two");
    chk("two_flags", {done, error, busy, cpu_hold, rx_ready}, 5'b10000);
    chk("hold_addr", wr_addr, 13'd1);

    // Checksum error.
    clear_log();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(fr[i]);
    send_byte(8'h29);
    idle_cycles(4);
    chk_two_words("csum");
    chk("csum_flags", {done, error, busy, cpu_hold}, 4'b0101);
    pulse_start();
    chk("restart_clr", {done, error, busy}, 3'b001);
    // Finish that frame correctly so the next test starts from DONE.
    for (int i = 0; i < 11; i++) send_byte(fr[i]);
    idle_cycles(2);

    // Overflow: 8193 words.
    clear_log();
    pulse_start();
    send_byte(8'h20);
    send_byte(8'h01);
    rx_valid = 1'b0;
    chk("ovf_state", {rx_ready, error, busy, cpu_hold, done}, 5'b01010);
    idle_cycles(3);
    chk("ovf_nwr", wa_q.size(), 0);

    // Largest legal length passes the range check and goes to DATA.
    pulse_start();
    send_byte(8'h20);
    send_byte(8'h00);
    chk("max_len_ok", {error, busy}, 2'b01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero length, throttled input.
    clear_log();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      idle_cycles(1);
      send_byte(8'h00);
    end
    rx_valid = 1'b0;
    idle_cycles(2);
    chk("zero_nwr", wa_q.size(), 0);
    chk("zero_flags", {done, error, busy}, 3'b100);

    // Reset mid-load after 6 data bytes.
    clear_log();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(fr[i]);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);
    chk("rst_mid_nwr", wa_q.size(), 1);
    chk("rst_mid_outs", {rx_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_hold}, '0);
    clear_log();
    pulse_start();
    for (int i = 0; i < 11; i++) send_byte(fr[i]);
    idle_cycles(2);
    chk_two_words("after_rst");
    chk("after_rst_done", {done, error}, 2'b10);

    // start while busy during DATA.
    clear_log();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(fr[i]);
    rx_valid = 1'b0;
    pulse_start();
    chk("busy_start", {busy, done, error}, 3'b100);
    for (int i = 7; i < 11; i++) send_byte(fr[i]);
    idle_cycles(2);
    chk_two_words("sb");
    chk("sb_done", {done, error}, 2'b10);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Write-side counterpart of the read-only 8k-word instruction memory.
- Receives a framed byte stream from the host link (UART receiver or debug bridge) and assembles 32-bit instruction words.
- Drives the memory's write port (port A wren/address/data) and verifies a trailing XOR checksum.
- Holds the CPU in reset while a program image is being loaded.

Parameters:
- ADDR_WIDTH, 13, instruction word-address width (8192 words).
- BASE_ADDR, 0, word address of the first loaded instruction.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when idle.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write enable (one-cycle pulse per word).
- wr_addr  output  ADDR_WIDTH  instruction memory write word address.
- wr_data  output  32  instruction word to write.
- busy  output  1  load in progress.
- done  output  1  last load completed with a good checksum.
- error  output  1  last load failed (overflow or checksum mismatch).
- cpu_hold  output  1  holds the CPU in reset; equals busy OR error.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, byte/word counters and running checksum cleared. A reset mid-load abandons the frame immediately; no further wr_en pulses.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes (each word big-endian, MSB first), then one checksum byte.
- Checksum: XOR of every preceding byte, including both length bytes.
- Byte transfer occurs only when rx_valid && rx_ready.
- rx_ready is 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in IDLE, DONE and ERROR. Bytes presented while rx_ready=0 are ignored (not consumed).
- IDLE/DONE/ERROR:
  - start=1 goes to LEN_HI.
  - Clears done, error, the checksum and the word index.
  - Sets busy.
- LEN_HI: latch length[15:8] and go to LEN_LO.
- LEN_LO: latch length[7:0], then:
  - If N > 2^ADDR_WIDTH - BASE_ADDR, go to ERROR. No writes occur.
  - Else if N == 0, go to CHECK.
  - Else go to DATA.
- DATA:
  - Shift each byte into a 32-bit assembly register.
  - On the 4th byte of a word, the following cycle shows wr_en=1, wr_addr=BASE_ADDR+word_index and wr_data=the assembled word. Latency is one cycle after the 4th byte handshake.
  - word_index increments after each write. Back-to-back bytes at full rate are sustained.
  - After word N-1's 4th byte, go to CHECK. That word's write pulse coincides with the first CHECK cycle.
- CHECK: compare the received byte against the running XOR.
  - Match: go to DONE, done=1.
  - Mismatch: go to ERROR, error=1.
  - Words already written stay in memory.
- busy: 1 in LEN_HI through CHECK; 0 otherwise.
- done and error are sticky until the next accepted start.
- start asserted while busy is ignored.
- wr_en is never asserted outside the cycle after a word completes.
- wr_addr and wr_data hold their last values when wr_en=0.
- The loader does not drive memory reads. Port B stays read-only for the fetch path.

Test Plan:
- Two-word load: start, then bytes 00 02 DE AD BE EF 12 34 56 78 28, rx_valid held high.
  - wr_en pulses twice: addr 0 data 0xDEADBEEF, then addr 1 data 0x12345678.
  - done=1, error=0, busy=0, cpu_hold=0.
- Checksum error: same frame with last byte 0x29.
  - Both writes still occur.
  - error=1, done=0, cpu_hold=1 until the next start.
- Overflow: ADDR_WIDTH=13, BASE_ADDR=0, length bytes 20 01 (8193 words).
  - ERROR entered right after LEN_LO; no wr_en pulses; rx_ready=0; error=1.
- Zero length with throttled input: bytes 00 00 00, with rx_valid toggling every other cycle.
  - No writes; done=1.
  - Only valid-cycle bytes are consumed.
- Reset mid-load: assert rst after 6 data bytes of a 2-word frame.
  - Exactly one write (word 0) occurred.
  - After rst all outputs are 0; the next start plus a full frame loads correctly.
- start while busy: pulse start during DATA.
  - No effect; word count and addresses continue unchanged.
